// File: rtl/mnist_pkg.sv
// mnist_pkg
//   Shared types and helpers for the MNIST inference pipeline.
//   feature_type   : signed 16-bit activation carried between stages
//   weight_type    : signed 16-bit weight / bias value
//   dense_state_t  : dense_layer control states
//   acc_width()    : accumulator width able to hold IN_SIZE 32-bit products
//   saturate_feature() : clamp a wide signed value into feature_type
package mnist_pkg;

   typedef logic signed [15:0] feature_type;
   typedef logic signed [15:0] weight_type;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_EMIT  = 1'b1
   } dense_state_t;

   localparam int PROD_W = 32;
   localparam int WIDE_W = 64;

   // One guard bit per doubling of the number of summed products.
   function automatic int acc_width(input int in_size);
      return PROD_W + $clog2(in_size);
   endfunction

   function automatic feature_type saturate_feature(input logic signed [WIDE_W-1:0] v);
      feature_type r;
      if (v > 64'sd32767) begin
         r = 16'sh7fff;
      end else if (v < -64'sd32768) begin
         r = 16'sh8000;
      end else begin
         r = v[15:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/feature_if.sv
// feature_if
//   Valid/ready stream carrying N features per beat.
//   valid    : producer has a beat on features
//   ready    : consumer accepts the beat this cycle
//   features : the payload, N entries of feature_type
interface feature_if #(
   parameter int N = 1
);
   import mnist_pkg::*;

   logic        valid;
   logic        ready;
   feature_type features [N];

   modport sink   (input valid, input features, output ready);
   modport source (output valid, output features, input ready);

endinterface

// File: rtl/dense_weight_mem.sv
// dense_weight_mem
//   IN_SIZE x NUM_OUT weight array plus NUM_OUT bias registers.
//   clock      : write clock
//   wt_we      : write strobe
//   wt_sel     : 0 = weight write, 1 = bias write
//   wt_row     : input index of a weight write (ignored for bias)
//   wt_col     : output neuron index
//   wt_data    : value written
//   rd_row     : row read combinationally, all columns on rd_weights
//   rd_col     : bias column read combinationally on rd_bias
//   Contents are never reset; they survive the pipeline reset.
module dense_weight_mem
   import mnist_pkg::*;
#(
   parameter int IN_SIZE = 9,
   parameter int NUM_OUT = 4
) (
   input  logic                       clock,
   input  logic                       wt_we,
   input  logic                       wt_sel,
   input  logic [$clog2(IN_SIZE)-1:0] wt_row,
   input  logic [$clog2(NUM_OUT)-1:0] wt_col,
   input  logic signed [15:0]         wt_data,
   input  logic [$clog2(IN_SIZE)-1:0] rd_row,
   output weight_type                 rd_weights [NUM_OUT],
   input  logic [$clog2(NUM_OUT)-1:0] rd_col,
   output weight_type                 rd_bias
);

   localparam int ROW_W = $clog2(IN_SIZE);
   localparam int COL_W = $clog2(NUM_OUT);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IN_SIZE - 1);

   weight_type bias_vec [NUM_OUT];

   // Each column owns its own storage so every array has a single writer.
   for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_col
      weight_type col_q [IN_SIZE];
      weight_type bias_q;
      logic       col_hit;

      assign col_hit = wt_we && (wt_col == COL_W'(gi));

      always_ff @(posedge clock) begin
         if (col_hit && !wt_sel && (wt_row <= LAST_ROW)) begin
            col_q[wt_row] <= wt_data;
         end
         if (col_hit && wt_sel) begin
            bias_q <= wt_data;
         end
      end

      assign rd_weights[gi] = col_q[rd_row];
      assign bias_vec[gi]   = bias_q;
   end

   assign rd_bias = bias_vec[rd_col];

endmodule

// File: rtl/dense_layer.sv
// dense_layer
//   Fully-connected stage: multiply-accumulates IN_SIZE streamed features
//   against a programmable weight matrix into NUM_OUT accumulators, then
//   streams NUM_OUT biased, rescaled, saturated (optionally ReLU'd) results.
//   clock        : system clock
//   reset        : synchronous active-high reset (weights are kept)
//   features_in  : sink stream, one feature per handshake, row-major
//   features_out : source stream, one neuron result per handshake
//   wt_we/wt_sel/wt_row/wt_col/wt_data : weight and bias write port
module dense_layer
   import mnist_pkg::*;
#(
   parameter int IN_SIZE   = 9,
   parameter int NUM_OUT   = 4,
   parameter int FRAC_BITS = 0,
   parameter int RELU      = 0
) (
   input  logic                       clock,
   input  logic                       reset,
   feature_if.sink                    features_in,
   feature_if.source                  features_out,
   input  logic                       wt_we,
   input  logic                       wt_sel,
   input  logic [$clog2(IN_SIZE)-1:0] wt_row,
   input  logic [$clog2(NUM_OUT)-1:0] wt_col,
   input  logic signed [15:0]         wt_data
);

   localparam int ROW_W = $clog2(IN_SIZE);
   localparam int COL_W = $clog2(NUM_OUT);
   localparam int ACC_W = acc_width(IN_SIZE);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IN_SIZE - 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_OUT - 1);

   typedef logic signed [ACC_W-1:0] acc_t;

   dense_state_t              state_q, state_d;
   logic [ROW_W-1:0]          in_idx_q, in_idx_d;
   logic [COL_W-1:0]          out_idx_q, out_idx_d;
   acc_t                      acc_q [NUM_OUT];
   acc_t                      acc_d [NUM_OUT];
   acc_t                      acc_sum [NUM_OUT];
   logic signed [PROD_W-1:0]  prod [NUM_OUT];
   logic                      valid_q, valid_d;
   feature_type               data_q, data_d;

   weight_type                row_w [NUM_OUT];
   weight_type                bias_rd;
   logic [COL_W-1:0]          res_sel;
   acc_t                      res_acc;
   feature_type               res_value;
   logic                      ready_w;
   logic                      in_hs;
   logic                      out_hs;

   // Bias add in the scaled domain, rescale, clamp, optional ReLU.
   function automatic feature_type finalize(input acc_t acc, input weight_type bias);
      logic signed [WIDE_W-1:0] sum;
      feature_type              r;
      sum = WIDE_W'(acc) + (WIDE_W'(bias) <<< FRAC_BITS);
      sum = sum >>> FRAC_BITS;
      r   = saturate_feature(sum);
      if ((RELU != 0) && r[15]) begin
         r = '0;
      end
      return r;
   endfunction

   dense_weight_mem #(
      .IN_SIZE (IN_SIZE),
      .NUM_OUT (NUM_OUT)
   ) u_mem (
      .clock      (clock),
      .wt_we      (wt_we),
      .wt_sel     (wt_sel),
      .wt_row     (wt_row),
      .wt_col     (wt_col),
      .wt_data    (wt_data),
      .rd_row     (in_idx_q),
      .rd_weights (row_w),
      .rd_col     (res_sel),
      .rd_bias    (bias_rd)
   );

   assign ready_w = (state_q == ST_ACCUM) && !reset;
   assign in_hs   = features_in.valid && ready_w;
   assign out_hs  = valid_q && features_out.ready;

   assign features_in.ready        = ready_w;
   assign features_out.valid       = valid_q;
   assign features_out.features[0] = data_q;

   for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_mac
      assign prod[gi]    = PROD_W'(features_in.features[0]) * PROD_W'(row_w[gi]);
      assign acc_sum[gi] = acc_q[gi] + ACC_W'(prod[gi]);
   end

   // Column whose result is registered on this edge: column 0 on the last
   // input (taking the accumulator including that final product), else the
   // column after the one currently being presented.
   assign res_sel   = ((state_q == ST_EMIT) && (out_idx_q != LAST_COL)) ? out_idx_q + 1'b1 : '0;
   assign res_acc   = (state_q == ST_ACCUM) ? acc_sum[0] : acc_q[res_sel];
   assign res_value = finalize(res_acc, bias_rd);

   always_comb begin
      state_d   = state_q;
      in_idx_d  = in_idx_q;
      out_idx_d = out_idx_q;
      valid_d   = valid_q;
      data_d    = data_q;
      for (int j = 0; j < NUM_OUT; j++) begin
         acc_d[j] = acc_q[j];
      end

      case (state_q)
         ST_ACCUM: begin
            if (in_hs) begin
               for (int j = 0; j < NUM_OUT; j++) begin
                  acc_d[j] = acc_sum[j];
               end
               if (in_idx_q == LAST_ROW) begin
                  in_idx_d  = '0;
                  out_idx_d = '0;
                  data_d    = res_value;
                  valid_d   = 1'b1;
                  state_d   = ST_EMIT;
               end else begin
                  in_idx_d = in_idx_q + 1'b1;
               end
            end
         end
         ST_EMIT: begin
            if (out_hs) begin
               if (out_idx_q == LAST_COL) begin
                  out_idx_d = '0;
                  valid_d   = 1'b0;
                  state_d   = ST_ACCUM;
                  for (int j = 0; j < NUM_OUT; j++) begin
                     acc_d[j] = '0;
                  end
               end else begin
                  out_idx_d = out_idx_q + 1'b1;
                  data_d    = res_value;
               end
            end
         end
         default: state_d = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_ACCUM;
         in_idx_q  <= '0;
         out_idx_q <= '0;
         valid_q   <= 1'b0;
         data_q    <= '0;
         for (int j = 0; j < NUM_OUT; j++) begin
            acc_q[j] <= '0;
         end
      end else begin
         state_q   <= state_d;
         in_idx_q  <= in_idx_d;
         out_idx_q <= out_idx_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         for (int j = 0; j < NUM_OUT; j++) begin
            acc_q[j] <= acc_d[j];
         end
      end
   end

endmodule

// File: tb/tb_dense_layer.sv
// tb_dense_layer
//   Directed bench for dense_layer. Three instances share all stimulus:
//   u_dut (defaults), u_relu (RELU=1) and u_frac (FRAC_BITS=4).
module tb_dense_layer;
   import mnist_pkg::*;

   logic               clock = 1'b0;
   logic               reset;
   logic               in_valid;
   logic signed [15:0] in_data;
   logic               out_ready;
   logic               wt_we;
   logic               wt_sel;
   logic [3:0]         wt_row;
   logic [1:0]         wt_col;
   logic signed [15:0] wt_data;

   int n_cmp = 0;
   int n_bad = 0;
   int overlap = 0;
   int q_a[$];
   int q_b[$];
   int q_c[$];

   feature_if in_a ();
   feature_if out_a ();
   feature_if in_b ();
   feature_if out_b ();
   feature_if in_c ();
   feature_if out_c ();

   assign in_a.valid = in_valid;
   assign in_a.features[0] = in_data;
   assign out_a.ready = out_ready;
   assign in_b.valid = in_valid;
   assign in_b.features[0] = in_data;
   assign out_b.ready = out_ready;
   assign in_c.valid = in_valid;
   assign in_c.features[0] = in_data;
   assign out_c.ready = out_ready;

   dense_layer u_dut (
      .clock (clock), .reset (reset),
      .features_in (in_a), .features_out (out_a),
      .wt_we (wt_we), .wt_sel (wt_sel), .wt_row (wt_row), .wt_col (wt_col), .wt_data (wt_data)
   );

   dense_layer #(.RELU(1)) u_relu (
      .clock (clock), .reset (reset),
      .features_in (in_b), .features_out (out_b),
      .wt_we (wt_we), .wt_sel (wt_sel), .wt_row (wt_row), .wt_col (wt_col), .wt_data (wt_data)
   );

   dense_layer #(.FRAC_BITS(4)) u_frac (
      .clock (clock), .reset (reset),
      .features_in (in_c), .features_out (out_c),
      .wt_we (wt_we), .wt_sel (wt_sel), .wt_row (wt_row), .wt_col (wt_col), .wt_data (wt_data)
   );

   always #5 clock = ~clock;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Output monitor: samples just after the driving edge; a beat with
   // valid && ready here is consumed on the following rising edge.
   initial begin
      forever begin
         @(negedge clock);
         #1;
         if (out_a.valid && out_ready) q_a.push_back(int'(out_a.features[0]));
         if (out_b.valid && out_ready) q_b.push_back(int'(out_b.features[0]));
         if (out_c.valid && out_ready) q_c.push_back(int'(out_c.features[0]));
         if (out_a.valid && in_a.ready) overlap++;
      end
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   task automatic wr(input bit sel, input int row, input int col, input int val);
      @(negedge clock);
      wt_we   = 1'b1;
      wt_sel  = sel;
      wt_row  = 4'(row);
      wt_col  = 2'(col);
      wt_data = 16'(val);
      @(negedge clock);
      wt_we   = 1'b0;
   endtask

   task automatic program_basic();
      for (int r = 0; r < 9; r++) begin
         wr(1'b0, r, 0, 1);
         wr(1'b0, r, 1, (r == 0) ? 1 : 0);
         wr(1'b0, r, 2, -1);
         wr(1'b0, r, 3, (r == 8) ? 2 : 0);
      end
      wr(1'b1, 0, 0, 0);
      wr(1'b1, 0, 1, 0);
      wr(1'b1, 0, 2, 100);
      wr(1'b1, 0, 3, -5);
   endtask

   // Sends the first n entries of f; returns just after the last handshake
   // edge with in_valid still high.
   task automatic send_frame(input int f [9], input int n);
      for (int i = 0; i < n; i++) begin
         int waitc;
         waitc = 0;
         @(negedge clock);
         in_valid = 1'b1;
         in_data  = 16'(f[i]);
         while (!in_a.ready && waitc < 50) begin
            @(negedge clock);
            waitc++;
         end
         if (waitc >= 50) check("in_ready_wait", longint'(in_a.ready), 1);
         @(posedge clock);
      end
   endtask

   task automatic wait_outputs(input string tag, input int n);
      int t;
      t = 0;
      while (q_a.size() < n && t < 100) begin
         @(negedge clock);
         #2;
         t++;
      end
      check({tag, "_count"}, q_a.size(), n);
   endtask

   function automatic int qget(input int which, input int k);
      case (which)
         0: return (k < q_a.size()) ? q_a[k] : -99999;
         1: return (k < q_b.size()) ? q_b[k] : -99999;
         default: return (k < q_c.size()) ? q_c[k] : -99999;
      endcase
   endfunction

   task automatic expect4(input string tag, input int which, input int base,
                          input int e0, input int e1, input int e2, input int e3);
      check({tag, "_o0"}, qget(which, base + 0), e0);
      check({tag, "_o1"}, qget(which, base + 1), e1);
      check({tag, "_o2"}, qget(which, base + 2), e2);
      check({tag, "_o3"}, qget(which, base + 3), e3);
   endtask

   task automatic clear_q();
      q_a.delete();
      q_b.delete();
      q_c.delete();
   endtask

   int basic [9];
   int flat [9];

   initial begin
      basic = '{8, 5, 9, 9, 8, 7, 7, 8, 9};
      reset = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b1;
      wt_we = 1'b0;
      wt_sel = 1'b0;
      wt_row = '0;
      wt_col = '0;
      wt_data = '0;

      // Weights are written while reset is held.
      program_basic();
      @(negedge clock);
      #1;
      check("rst_in_ready", longint'(in_a.ready), 0);
      check("rst_out_valid", longint'(out_a.valid), 0);
      check("rst_out_data", out_a.features[0], 0);
      check("rst_relu_valid", longint'(out_b.valid), 0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("post_rst_in_ready", longint'(in_a.ready), 1);

      // Basic frame with latency and ready-return checks.
      clear_q();
      send_frame(basic, 9);
      @(negedge clock);
      in_valid = 1'b0;
      #1;
      check("latency_valid", longint'(out_a.valid), 1);
      check("latency_data", out_a.features[0], 70);
      check("emit_in_ready", longint'(in_a.ready), 0);
      wait_outputs("basic", 4);
      expect4("basic", 0, 0, 70, 8, 30, 13);
      @(negedge clock);
      #1;
      check("done_valid", longint'(out_a.valid), 0);
      check("done_in_ready", longint'(in_a.ready), 1);

      // Backpressure: ready low for 3 cycles after the 2nd output.
      clear_q();
      send_frame(basic, 9);
      @(negedge clock);
      in_valid = 1'b0;
      @(negedge clock);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         out_ready = 1'b0;
         #1;
         check("bp_hold_data", out_a.features[0], 30);
         check("bp_hold_valid", longint'(out_a.valid), 1);
         check("bp_in_ready", longint'(in_a.ready), 0);
      end
      @(negedge clock);
      out_ready = 1'b1;
      wait_outputs("bp", 4);
      expect4("bp", 0, 0, 70, 8, 30, 13);

      // Back-to-back frames with input valid held high.
      clear_q();
      send_frame(basic, 9);
      send_frame(basic, 9);
      @(negedge clock);
      in_valid = 1'b0;
      wait_outputs("b2b", 8);
      expect4("b2b_f0", 0, 0, 70, 8, 30, 13);
      expect4("b2b_f1", 0, 4, 70, 8, 30, 13);

      // Reset after 4 inputs discards the partial frame.
      clear_q();
      send_frame(basic, 4);
      @(negedge clock);
      in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      send_frame(basic, 9);
      @(negedge clock);
      in_valid = 1'b0;
      wait_outputs("midrst", 4);
      expect4("midrst", 0, 0, 70, 8, 30, 13);
      check("emit_overlap", overlap, 0);

      // Saturation and ReLU: inputs 200, col0 weights 127, col1 weights -127.
      for (int r = 0; r < 9; r++) begin
         wr(1'b0, r, 0, 127);
         wr(1'b0, r, 1, -127);
         flat[r] = 200;
      end
      clear_q();
      send_frame(flat, 9);
      @(negedge clock);
      in_valid = 1'b0;
      wait_outputs("sat", 4);
      expect4("sat", 0, 0, 32767, -32768, -1700, 395);
      expect4("sat_relu", 1, 0, 32767, 0, 0, 395);

      // Fraction bits: inputs 16, col0 weights 16, bias0 = 1.
      for (int r = 0; r < 9; r++) begin
         wr(1'b0, r, 0, 16);
         flat[r] = 16;
      end
      wr(1'b1, 0, 0, 1);
      clear_q();
      send_frame(flat, 9);
      @(negedge clock);
      in_valid = 1'b0;
      wait_outputs("frac", 4);
      expect4("frac_f4", 2, 0, 145, -1143, 91, -3);
      expect4("frac_f0", 0, 0, 2305, -18288, -44, 27);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dense_layer.md
Name: dense_layer

Overview:
- Fully-connected (dense) stage directly downstream of max_pool in the MNIST pipeline.
- Consumes the pooled feature stream (one feature per handshake, row-major order) and multiply-accumulates each feature against a programmable weight matrix into NUM_OUT parallel accumulators.
- After a full frame of IN_SIZE features, adds the biases, rescales, saturates, optionally applies ReLU, then streams NUM_OUT results out in index order.

Parameters:
- IN_SIZE, 9: features per frame (pool output height × width).
- NUM_OUT, 4: number of output neurons.
- FRAC_BITS, 0: fixed-point fraction bits; the sum is arithmetic-shifted right by this amount before saturation.
- RELU, 0: 1 = clamp negative results to 0.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- features_in  feature_if (sink)  valid/ready/features[0]  pooled features in; features[0] is feature_type from mnist_pkg (signed 16 bit).
- features_out  feature_if (source)  valid/ready/features[0]  neuron results out.
- wt_we  input  1  weight/bias write strobe.
- wt_sel  input  1  0 = weight, 1 = bias.
- wt_row  input  $clog2(IN_SIZE)  input index (ignored for bias writes).
- wt_col  input  $clog2(NUM_OUT)  output neuron index.
- wt_data  input  16  signed weight or bias value.

Behaviour:
- Clock and reset: one clock; reset is synchronous, active-high.
- Reset values:
  - state = ACCUM, in_idx = 0, out_idx = 0, all accumulators = 0.
  - features_in.ready = 0 while reset is high.
  - features_out.valid = 0, features_out.features[0] = 0.
  - Weight and bias storage is not reset; it retains its contents.
- ACCUM state:
  - features_in.ready = 1.
  - On handshake (valid && ready): for every j, acc[j] += features[0] * W[in_idx][j], all NUM_OUT in parallel; then in_idx++.
  - On the handshake with in_idx == IN_SIZE-1: in_idx resets to 0, the first result is registered, and the FSM moves to EMIT.
- EMIT state:
  - features_in.ready = 0.
  - features_out.valid = 1 with the registered result for out_idx.
  - On output handshake: out_idx++ and the next result is registered in the same edge (no bubble).
  - On the handshake with out_idx == NUM_OUT-1: valid drops, all accumulators clear to 0, the FSM returns to ACCUM, and ready rises the next cycle.
- Latency: first output is valid the cycle after the last input handshake. Throughput is 1 feature/cycle in and 1 result/cycle out.
- Result arithmetic:
  - ACC_W = 32 + $clog2(IN_SIZE) signed; products are 32-bit signed.
  - r = (acc[j] + (bias[j] <<< FRAC_BITS)) >>> FRAC_BITS.
  - r is saturated to [-32768, 32767].
  - If RELU = 1, r < 0 becomes 0.
- Backpressure: while valid && !ready, features_out.features[0] and out_idx hold stable. Input valid while not ready is ignored; no data is lost or consumed.
- Weight writes:
  - Accepted on any cycle wt_we = 1, including during reset.
  - Visible to MACs from the next cycle.
  - Mid-frame bias writes affect the current frame's results. Mid-frame weight writes affect only the remaining inputs of the frame.
- Reset mid-frame or mid-emit: the partial frame is discarded, and the next accepted feature is index 0 of a new frame.

Decomposition:
- mnist_pkg holds:
  - feature_type (signed 16) and weight_type (signed 16).
  - acc_type width function.
  - A saturate_feature() function that clamps a wide signed value to feature_type.
- One sub-module, dense_weight_mem: IN_SIZE × NUM_OUT weight array plus NUM_OUT bias registers. It has a write port and a combinational read of row in_idx (all columns) plus a bias read by out_idx.
- The FSM, counters and accumulators live in dense_layer.

Test Plan:
- Basic frame, defaults:
  - Input 8,5,9,9,8,7,7,8,9.
  - Weights and biases:
    - col0: all weights 1, bias 0.
    - col1: weight 1 at row0 only, bias 0.
    - col2: all weights -1, bias 100.
    - col3: weight 2 at row8, bias -5.
  - Required outputs in order: 70, 8, 30, 13.
  - First valid the cycle after the 9th input handshake.
- Saturation:
  - All inputs 200, col0 weights 127 → 32767.
  - col1 weights -127 → -32768.
  - Rerun with RELU=1 → col1 = 0.
- Backpressure:
  - Same frame as the basic test, with features_out.ready low for 3 cycles after the 2nd output.
  - Data holds at 30 while stalled, and the output sequence is unchanged.
  - features_in.ready stays 0 throughout emission.
- Back-to-back frames:
  - Two frames with the input valid held continuously.
  - Both frames give 70, 8, 30, 13; the accumulators are cleared between frames.
- Reset mid-frame:
  - Assert reset after the 4th input handshake, then send the full basic frame.
  - Outputs are exactly 70, 8, 30, 13, and the weights are retained across reset.
- FRAC_BITS=4:
  - Inputs all 16, col0 weights all 16, bias 1.
  - Required output (9·256 + 16) >>> 4 = 145.
